trng_vn_conditioner: RTL and testbench

- Downstream conditioning stage for the SR-latch entropy source.
- Consumes synchronized raw bits and removes bias with a von Neumann corrector.
- Packs debiased bits into bytes, presented on a valid/ready interface for the chip-level output mux.
- Runs a repetition-count health test on the raw stream and blocks output when the source appears stuck.

---
 rtl/trng_vn_conditioner.sv | 131 +++++++++++++
 tb/tb_trng_vn_conditioner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_vn_conditioner.sv
// Von Neumann debiasing, byte packing and repetition-count health test for
// the SR-latch entropy source; bytes leave on a valid/ready interface.
module trng_vn_conditioner #(
    parameter int unsigned RCT_CUTOFF = 32,
    parameter int unsigned DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              raw_bit,
    input  logic              raw_valid,
    input  logic              health_clr,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              health_fail,
    output logic [DROP_W-1:0] drop_count
);

    localparam logic [7:0] CUTOFF = 8'(RCT_CUTOFF);

    logic       accept;
    logic       pair_vld, pair_bit;
    logic       have_last, last_bit;
    logic [7:0] rep_cnt;
    logic       emit_vld, emit_bit;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] full_byte;
    logic       pack_bit, byte_done, load;

    assign accept = en & raw_valid & ~health_clr;

    // Pair flag and first half of the pair; a disabled cycle abandons the half-pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_vld <= 1'b0;
            pair_bit <= 1'b0;
        end else if (health_clr || !en) begin
            pair_vld <= 1'b0;
        end else if (accept) begin
            if (!pair_vld) begin
                pair_vld <= 1'b1;
                pair_bit <= raw_bit;
            end else begin
                pair_vld <= 1'b0;
            end
        end
    end

    // Corrector output stage: the emitted bit equals the first bit of an unequal pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_vld <= 1'b0;
            emit_bit <= 1'b0;
        end else begin
            emit_vld <= accept & pair_vld & (pair_bit != raw_bit);
            emit_bit <= pair_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_last <= 1'b0;
            last_bit  <= 1'b0;
            rep_cnt   <= '0;
        end else if (health_clr) begin
            have_last <= 1'b0;
            rep_cnt   <= '0;
        end else if (accept) begin
            have_last <= 1'b1;
            last_bit  <= raw_bit;
            if (have_last && (raw_bit == last_bit))
                rep_cnt <= (rep_cnt == '1) ? rep_cnt : rep_cnt + 8'd1;
            else
                rep_cnt <= 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            health_fail <= 1'b0;
        else if (health_clr)
            health_fail <= 1'b0;
        else if (rep_cnt >= CUTOFF)
            health_fail <= 1'b1;
    end

    // Bits emitted while the source is flagged are discarded at the packer.
    assign pack_bit  = emit_vld & ~health_fail & ~health_clr;
    assign byte_done = pack_bit & (bit_cnt == 3'd7);
    assign load      = byte_done & (~out_valid | out_ready);

    always_comb begin
        full_byte          = shreg;
        full_byte[bit_cnt] = emit_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (health_clr) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (pack_bit) begin
            shreg[bit_cnt] <= emit_bit;
            bit_cnt        <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= full_byte;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count <= '0;
        else if (byte_done && !load && (drop_count != '1))
            drop_count <= drop_count + {{(DROP_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_trng_vn_conditioner.sv
// Scoreboard bench for trng_vn_conditioner: a bit-list reference model predicts
// bytes and drops, a monitor compares every transfer.
module tb_trng_vn_conditioner;

    localparam int CUT = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic       health_clr = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       health_fail;
    logic [7:0] drop_count;

    trng_vn_conditioner #(.RCT_CUTOFF(CUT), .DROP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .health_clr(health_clr), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .health_fail(health_fail), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [7:0] sb[$];
    int         m_half = -1;
    int         m_bits[$];
    int         m_run = 0;
    int         m_last = 0;
    bit         m_fail = 1'b0;
    int         m_drops = 0;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Reference: rdy is the consumer's ready in the cycle the completed byte would load.
    function automatic void model_sample(int b, bit rdy);
        int emitted = -1;
        int v = 0;
        if (m_half < 0) m_half = b;
        else begin
            if (m_half != b) emitted = m_half;
            m_half = -1;
        end
        if (emitted >= 0 && !m_fail) begin
            m_bits.push_back(emitted);
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) v += m_bits[i] << i;
                m_bits.delete();
                if (rdy || sb.size() == 0) sb.push_back(8'(v));
                else if (m_drops < 255) m_drops++;
            end
        end
        if (m_run > 0 && b == m_last) m_run++;
        else m_run = 1;
        m_last = b;
        if (m_run >= CUT) m_fail = 1'b1;
    endfunction

    function automatic void model_clear();
        m_half = -1;
        m_bits.delete();
        m_run  = 0;
        m_fail = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int b, input bit r1);
        raw_valid = 1'b1;
        raw_bit   = b[0];
        tick();
        raw_valid = 1'b0;
        out_ready = r1;
        model_sample(b, r1);
        tick();
    endtask

    task automatic send_pair(input int b, input bit r1);
        sample(b, out_ready);
        sample(1 - b, r1);
    endtask

    task automatic pulse_clr();
        health_clr = 1'b1;
        raw_valid  = 1'b1;
        raw_bit    = 1'($urandom_range(1));
        tick();
        health_clr = 1'b0;
        raw_valid  = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic drain(string name);
        int n = 0;
        out_ready = 1'b1;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check({name, "_drained"}, sb.size(), 0);
        tick();
        check({name, "_idle"}, out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_byte: got 0x%0h expected no output", out_data);
            end else begin
                check("byte", out_data, sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int     rb;
        logic [7:0] held;
        int     ddrop;

        repeat (3) tick();
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_health_fail", health_fail, 0);
        check("rst_drop_count", drop_count, 0);
        rst_n = 1'b1;
        en = 1'b1;
        out_ready = 1'b1;
        tick();

        // Debias/pack with two discarded pairs.
        begin
            int pat[20] = '{1,0, 0,1, 0,0, 1,0, 1,1, 1,0, 0,1, 0,1, 1,0, 0,1};
            foreach (pat[i]) sample(pat[i], 1'b1);
        end
        drain("debias");

        // Backpressure: three bytes with no consumer.
        out_ready = 1'b0;
        repeat (24) send_pair(int'($urandom_range(1)), 1'b0);
        check("bp_valid", out_valid, 1);
        check("bp_held", out_data, sb[0]);
        check("bp_drop", drop_count, m_drops);
        out_ready = 1'b1;
        tick();
        check("bp_fall", out_valid, 0);
        tick();

        // Asynchronous reset with a held byte and three drops.
        out_ready = 1'b0;
        repeat (16) send_pair(int'($urandom_range(1)), 1'b0);
        check("pre_rst_drop", drop_count, m_drops);
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_drop", drop_count, 0);
        check("arst_fail", health_fail, 0);
        sb.delete();
        model_clear();
        m_drops = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Simultaneous drain and load.
        out_ready = 1'b0;
        repeat (8) send_pair(int'($urandom_range(1)), 1'b0);
        repeat (7) send_pair(int'($urandom_range(1)), 1'b0);
        ddrop = m_drops;
        rb = int'($urandom_range(1));
        sample(rb, 1'b0);
        sample(1 - rb, 1'b1);
        check("simul_valid", out_valid, 1);
        check("simul_drop", drop_count, ddrop);
        drain("simul");

        // Health trip and clear.
        pulse_clr();
        repeat (31) sample(1, 1'b1);
        tick();
        check("rct_31", health_fail, m_fail);
        sample(1, 1'b1);
        check("rct_32", health_fail, m_fail);
        repeat (16) send_pair(int'($urandom_range(1)), 1'b1);
        check("rct_no_out", out_valid, 0);
        pulse_clr();
        check("rct_clr", health_fail, 0);
        repeat (8) send_pair(int'($urandom_range(1)), 1'b1);
        drain("post_clr");

        // en gap mid-pair with a 4-bit partial byte.
        repeat (4) send_pair(int'($urandom_range(1)), 1'b1);
        sample(int'($urandom_range(1)), 1'b1);
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        m_half = -1;
        repeat (4) send_pair(int'($urandom_range(1)), 1'b1);
        drain("en_gap");

        // Random traffic with random backpressure and enable gaps.
        for (int it = 0; it < 1500; it++) begin
            int act = int'($urandom_range(99));
            if (act < 85) begin
                sample(int'($urandom_range(1)), ($urandom_range(9) < 7));
            end else if (act < 95) begin
                tick();
            end else begin
                en = 1'b0;
                repeat ($urandom_range(4, 1)) tick();
                en = 1'b1;
                m_half = -1;
            end
        end
        drain("random");
        check("final_drop", drop_count, m_drops);
        check("final_fail", health_fail, m_fail);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
